// File: rtl/clkmgr_root_gate_req.sv
// Requester side of the root clock-gate handshake with idle hysteresis and ack timeout.
// Optional CLKMGR_ROOT_GATE_REQ_STATS_EN adds gate_cnt_o, a saturating count of completed enables.
module clkmgr_root_gate_req #(
  parameter int unsigned IdleCycles    = 8,
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned SyncStages    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sw_en_i,
  input  logic        idle_i,
  input  logic        en_fb_i,
  output logic        async_en_o,
  output logic        status_o,
  output logic        busy_o,
  output logic        err_timeout_o
`ifdef CLKMGR_ROOT_GATE_REQ_STATS_EN
  ,
  output logic [15:0] gate_cnt_o
`endif
);

  localparam int unsigned IdleW = $clog2(IdleCycles + 1);
  localparam int unsigned ToW   = $clog2(TimeoutCycles + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TimeoutCycles - 1);

  // Sparse encoding so corrupted state bits land on decodable invalid values.
  typedef enum logic [2:0] {
    StOff     = 3'b000,
    StWaitOn  = 3'b011,
    StOn      = 3'b101,
    StWaitOff = 3'b110
  } state_e;

  state_e                   state_q, state_d;
  logic [SyncStages-1:0]    fb_sync_q;
  logic                     fb_s;
  logic [IdleW-1:0]         idle_cnt_q, idle_cnt_d;
  logic [ToW-1:0]           to_cnt_q, to_cnt_d;
  logic                     async_en_q, async_en_d;
  logic                     err_q, err_d;
  logic                     on_done;

  function automatic logic [IdleW-1:0] idle_sat_inc(input logic [IdleW-1:0] v);
    return (v == {IdleW{1'b1}}) ? v : v + IdleW'(1);
  endfunction

  // Feedback synchronizer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fb_sync_q <= '0;
    end else begin
      fb_sync_q <= {fb_sync_q[SyncStages-2:0], en_fb_i};
    end
  end

  assign fb_s = fb_sync_q[SyncStages-1];

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    to_cnt_d   = '0;
    err_d      = 1'b0;
    on_done    = 1'b0;
    case (state_q)
      StOff: begin
        if (sw_en_i) state_d = StWaitOn;
      end
      StWaitOn: begin
        if (fb_s) begin
          state_d = StOn;
          on_done = 1'b1;
        end else if (to_cnt_q == ToLast) begin
          err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StOn: begin
        if (!sw_en_i && idle_i) begin
          if (idle_cnt_q == IdleLast) state_d = StWaitOff;
          else                        idle_cnt_d = idle_sat_inc(idle_cnt_q);
        end
      end
      StWaitOff: begin
        if (!fb_s) begin
          state_d = StOff;
        end else if (to_cnt_q == ToLast) begin
          err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      default: begin
        state_d = StOff;
        err_d   = 1'b1;
      end
    endcase
  end

  // Enable request follows the state one cycle late, so it never glitches on decode.
  assign async_en_d = (state_q == StWaitOn) || (state_q == StOn);

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StOff;
      idle_cnt_q <= '0;
      to_cnt_q   <= '0;
      async_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      to_cnt_q   <= to_cnt_d;
      async_en_q <= async_en_d;
      err_q      <= err_d;
    end
  end

  assign async_en_o    = async_en_q;
  assign status_o      = fb_s;
  assign busy_o        = (state_q == StWaitOn) || (state_q == StWaitOff);
  assign err_timeout_o = err_q;

`ifdef CLKMGR_ROOT_GATE_REQ_STATS_EN
  logic [15:0] gate_cnt_q;

  function automatic logic [15:0] cnt16_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      gate_cnt_q <= '0;
    else if (on_done) gate_cnt_q <= cnt16_sat_inc(gate_cnt_q);
  end

  assign gate_cnt_o = gate_cnt_q;
`else
  logic unused_on_done;
  assign unused_on_done = on_done;
`endif

endmodule

// File: tb/tb_clkmgr_root_gate_req.sv
// Self-checking bench for clkmgr_root_gate_req: vector table plus multi-cycle handshake sequences.
// Outputs are packed {async_en_o, status_o, busy_o, err_timeout_o} and compared via a scoreboard queue.
module tb_clkmgr_root_gate_req;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_en, idle, fb_drv, fb_loop;
  logic en_fb;
  logic async_en, status, busy, err_to;
  logic [1:0] dly = 2'b00;
`ifdef CLKMGR_ROOT_GATE_REQ_STATS_EN
  logic [15:0] gate_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sw;
    logic       idle;
    logic       fb;
    logic [3:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  // Stand-in root gating controller: echoes the request back two cycles later.
  always @(posedge clk) dly <= {dly[0], async_en};
  assign en_fb = fb_loop ? dly[1] : fb_drv;

  clkmgr_root_gate_req #(
    .IdleCycles   (8),
    .TimeoutCycles(64),
    .SyncStages   (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sw_en_i      (sw_en),
    .idle_i       (idle),
    .en_fb_i      (en_fb),
    .async_en_o   (async_en),
    .status_o     (status),
    .busy_o       (busy),
    .err_timeout_o(err_to)
`ifdef CLKMGR_ROOT_GATE_REQ_STATS_EN
    ,
    .gate_cnt_o   (gate_cnt)
`endif
  );

  function automatic void add(input logic sw, input logic idl, input logic fb,
                              input logic [3:0] exp, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{sw, idl, fb, exp});
  endfunction

  task automatic check_out(input string name, input int idx);
    logic [3:0] got, req;
    got = {async_en, status, busy, err_to};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: scoreboard empty, got %b", name, idx, got);
    end else begin
      req = sb.pop_front();
      if (got !== req) begin
        errors++;
        $display("FAIL %s[%0d]: {async_en,status,busy,err} got %b required %b",
                 name, idx, got, req);
      end
    end
  endtask

  task automatic step(input logic sw, input logic idl, input logic fb,
                      input logic [3:0] exp, input string name, input int idx);
    sw_en  = sw;
    idle   = idl;
    fb_drv = fb;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name, idx);
  endtask

  task automatic do_reset(input logic loop);
    rst_n   = 1'b0;
    sw_en   = 1'b0;
    idle    = 1'b0;
    fb_drv  = 1'b0;
    fb_loop = loop;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    logic       sw_b;

    // Reset state, sw_en held high as in the bring-up scenario
    do_reset(1'b0);
    sw_en = 1'b1;
    #1;
    sb.push_back(4'b0000);
    check_out("reset", 0);
    rst_n = 1'b1;

    // Bring-up with 2-cycle controller delay, then idle hysteresis and power-down
    add(1, 0, 0, 4'b0010, 1);
    add(1, 0, 0, 4'b1010, 3);
    add(1, 0, 1, 4'b1010, 1);
    add(1, 0, 1, 4'b1110, 1);
    add(1, 0, 1, 4'b1100, 2);
    add(0, 1, 1, 4'b1100, 7);
    add(0, 0, 1, 4'b1100, 1);
    add(0, 1, 1, 4'b1100, 7);
    add(0, 1, 1, 4'b1110, 1);
    add(0, 1, 1, 4'b0110, 3);
    add(0, 1, 0, 4'b0110, 1);
    add(0, 1, 0, 4'b0010, 1);
    add(0, 1, 0, 4'b0000, 2);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].sw, tbl[i].idle, tbl[i].fb, tbl[i].exp, "table", i + 1);

    // sw_en dropped in StWaitOn, then raised again during StWaitOff
    do_reset(1'b1);
    rst_n = 1'b1;
    for (int n = 1; n <= 28; n++) begin
      sw_b = (n == 1) || (n >= 18);
      e[3] = (n >= 2 && n <= 15) || (n >= 23);
      e[2] = (n >= 6 && n <= 19) || (n >= 27);
      e[1] = (n <= 6) || (n >= 15 && n <= 20) || (n >= 22 && n <= 27);
      e[0] = 1'b0;
      step(sw_b, 1'b1, 1'b0, e, "toggle", n);
    end

    // Controller never acknowledges: periodic timeout pulses
    do_reset(1'b0);
    rst_n = 1'b1;
    for (int n = 1; n <= 130; n++) begin
      e = {(n >= 2), 1'b0, 1'b1, (n == 65 || n == 129)};
      step(1'b1, 1'b0, 1'b0, e, "timeout", n);
    end

    // Asynchronous reset while in StWaitOn
    rst_n = 1'b0;
    #1;
    sb.push_back(4'b0000);
    check_out("rst_mid", 0);

`ifdef CLKMGR_ROOT_GATE_REQ_STATS_EN
    checks++;
    if (gate_cnt !== 16'd0) begin
      errors++;
      $display("FAIL gate_cnt_reset: got %0d required 0", gate_cnt);
    end
    do_reset(1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sw_en = 1'b1;
      idle  = 1'b1;
      @(posedge clk);
      #1;
      sw_en = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (gate_cnt !== 16'(c + 1) || busy !== 1'b0 || async_en !== 1'b0) begin
        errors++;
        $display("FAIL gate_cnt[%0d]: got cnt=%0d busy=%b en=%b required cnt=%0d busy=0 en=0",
                 c, gate_cnt, busy, async_en, c + 1);
      end
    end
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
